pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the fetch stage: generates the instruction-memory address each cycle. Selects between sequential increment, pipeline flush redirect, N prioritised jump sources and a hardware return-address stack (RAS) for call/return. Sits ahead of instruction memory and is driven by the decode and execute stages' jump, call, return and flush outputs.

## Interface
- ADDR_WIDTH, 16, PC and target address width
- NUM_JMP, 2, number of jump request ports; port 0 is highest priority
- RAS_DEPTH, 4, return-address stack entries, power of two, ≥2
- RESET_VECTOR, 0, PC value after reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately
- stall  in  1  hold all state (PC, RAS, flags) this cycle
- flush  in  1  redirect to flush_address (mispredict recovery)
- flush_address  in  ADDR_WIDTH  flush target
- jmp_valid  in  NUM_JMP  per-port jump request
- jmp_call  in  NUM_JMP  per-port: jump is a call, push link
- jmp_address  in  NUM_JMP*ADDR_WIDTH  per-port target, port i at bits [i*AW +: AW]
- jmp_link  in  NUM_JMP*ADDR_WIDTH  per-port return address to push on call
- ret_valid  in  1  return request: pop RAS, jump to popped address
- pc  out  ADDR_WIDTH  current fetch address
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_overflow  out  1  sticky: push into full RAS occurred
- ras_underflow  out  1  sticky: return with empty RAS occurred

## Operation
- Next-PC priority, highest first: reset > stall > flush > ret_valid > lowest-index jmp_valid > pc+1.
- reset low: pc=RESET_VECTOR, ras_count=0, both sticky flags 0, RAS storage contents don't-care.
- stall: pc, RAS pointer, count, flags all hold; every other input ignored that cycle.
- flush: pc<=flush_address; any simultaneous ret or call is dropped (no push/pop). RAS contents kept.
- ret_valid, count>0: pc<=top entry; pop (count-1). ret_valid, count==0: pc<=pc+1, ras_underflow<=1, no pointer change.
- Jump: winning port k (lowest index with jmp_valid set): pc<=jmp_address[k]; if jmp_call[k], push jmp_link[k]. Losing ports ignored entirely, including their call bits.
- Push when count==RAS_DEPTH: circular overwrite of oldest entry, count stays RAS_DEPTH, ras_overflow<=1.
- Increment wraps modulo 2^ADDR_WIDTH (all-ones → 0).
- ret_valid with any jmp_valid: return wins, no push.
- Sticky flags clear only on reset.

## Timing
- Single-cycle: inputs sampled at edge t, pc valid after edge t; no internal latency.
- RAS top readable combinationally, so back-to-back call then return in consecutive cycles returns the just-pushed link.
- Reset assertion asynchronous; deassertion synchronised externally; first increment on first edge after release.

## Structure
- Shared package pc_pkg: pc_sel_t enum {PC_SEL_INC, PC_SEL_FLUSH, PC_SEL_RET, PC_SEL_JMP}; helper constant RAS_PTR_BITS function.
- Sub-module return_address_stack (params DEPTH, WIDTH; ports clk, reset, push, pop, push_data, top, count, overflow, underflow); circular buffer with top pointer.
- Top: priority encoder over jmp_valid, next-PC mux driven by pc_sel_t, PC register.

## Test plan
- Reset low mid-run at pc=0x0042 → pc=0x0000 immediately; release, 3 edges → pc=0x0003.
- pc=0xFFFF, no requests → next pc=0x0000.
- jmp_valid=2'b11, addr0=0x0100, addr1=0x0200, call1=1 → pc=0x0100, ras_count unchanged; stall asserted with flush → pc holds.
- Call to 0x0300 link 0x0011, next cycle ret_valid → pc=0x0011, ras_count 1→0; further ret → pc=0x0012, ras_underflow=1.
- 5 calls, links 0x1..0x5, RAS_DEPTH=4 → ras_overflow=1, count=4; 4 returns yield 0x5,0x4,0x3,0x2.
- flush=1 to 0x0400 with ret_valid and call on port 0 → pc=0x0400, ras_count unchanged.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage PC sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEL_INC,
    PC_SEL_FLUSH,
    PC_SEL_RET,
    PC_SEL_JMP
  } pc_sel_t;

  function automatic int RAS_PTR_BITS(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack; a push into a full stack
// overwrites the oldest entry.
module return_address_stack
  import pc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = RAS_PTR_BITS(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_inc;
  logic             full;
  logic             empty;

  assign ptr_inc = ptr + PW'(1);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign top     = mem[ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (push) begin
      ptr <= ptr_inc;
      if (full) overflow <= 1'b1;
      else      count    <= count + CW'(1);
    end else if (pop) begin
      if (empty) begin
        underflow <= 1'b1;
      end else begin
        ptr   <= ptr - PW'(1);
        count <= count - CW'(1);
      end
    end
  end

  // Storage is not reset; count alone marks valid entries.
  always_ff @(posedge clk) begin
    if (push) mem[ptr_inc] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: flush, return, prioritised jumps and
// sequential increment, with a hardware return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                  ADDR_WIDTH   = 16,
  parameter int                  NUM_JMP      = 2,
  parameter int                  RAS_DEPTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          flush,
  input  logic [ADDR_WIDTH-1:0]         flush_address,
  input  logic [NUM_JMP-1:0]            jmp_valid,
  input  logic [NUM_JMP-1:0]            jmp_call,
  input  logic [NUM_JMP*ADDR_WIDTH-1:0] jmp_address,
  input  logic [NUM_JMP*ADDR_WIDTH-1:0] jmp_link,
  input  logic                          ret_valid,
  output logic [ADDR_WIDTH-1:0]         pc,
  output logic [$clog2(RAS_DEPTH):0]    ras_count,
  output logic                          ras_overflow,
  output logic                          ras_underflow
);

  localparam int JW = (NUM_JMP > 1) ? $clog2(NUM_JMP) : 1;

  pc_sel_t               sel;
  logic                  jmp_hit;
  logic [JW-1:0]         jmp_idx;
  logic [ADDR_WIDTH-1:0] jmp_target;
  logic [ADDR_WIDTH-1:0] jmp_ret_link;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  push;
  logic                  pop;

  // Scan downward so the lowest-index request is left standing.
  always_comb begin
    jmp_hit = 1'b0;
    jmp_idx = '0;
    for (int i = NUM_JMP - 1; i >= 0; i--) begin
      if (jmp_valid[i]) begin
        jmp_hit = 1'b1;
        jmp_idx = JW'(i);
      end
    end
  end

  assign jmp_target   = jmp_address[jmp_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign jmp_ret_link = jmp_link[jmp_idx*ADDR_WIDTH +: ADDR_WIDTH];

  always_comb begin
    sel = PC_SEL_INC;
    if (flush)                          sel = PC_SEL_FLUSH;
    else if (ret_valid && ras_count != '0) sel = PC_SEL_RET;
    else if (ret_valid)                 sel = PC_SEL_INC;
    else if (jmp_hit)                   sel = PC_SEL_JMP;
  end

  assign pop  = !stall && !flush && ret_valid;
  assign push = !stall && !flush && !ret_valid
             && jmp_hit && jmp_call[jmp_idx];

  always_comb begin
    pc_next = pc + ADDR_WIDTH'(1);
    unique case (sel)
      PC_SEL_FLUSH: pc_next = flush_address;
      PC_SEL_RET:   pc_next = ras_top;
      PC_SEL_JMP:   pc_next = jmp_target;
      default:      pc_next = pc + ADDR_WIDTH'(1);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     pc <= RESET_VECTOR;
    else if (!stall) pc <= pc_next;
  end

  return_address_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (jmp_ret_link),
    .top       (ras_top),
    .count     (ras_count),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [15:0] flush_address;
  logic [1:0]  jmp_valid;
  logic [1:0]  jmp_call;
  logic [31:0] jmp_address;
  logic [31:0] jmp_link;
  logic        ret_valid;
  logic [15:0] pc;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .ADDR_WIDTH   (16),
    .NUM_JMP      (2),
    .RAS_DEPTH    (4),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .flush_address (flush_address),
    .jmp_valid     (jmp_valid),
    .jmp_call      (jmp_call),
    .jmp_address   (jmp_address),
    .jmp_link      (jmp_link),
    .ret_valid     (ret_valid),
    .pc            (pc),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [15:0] fa;
    logic        ret;
    logic [1:0]  jv;
    logic [1:0]  jc;
    logic [15:0] a0, a1, l0, l1;
    logic [15:0] epc;
    logic [2:0]  ecnt;
    logic        eovf, eunf;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic st, input logic fl, input logic [15:0] fa,
    input logic rt, input logic [1:0] jv, input logic [1:0] jc,
    input logic [15:0] a0, input logic [15:0] a1,
    input logic [15:0] l0, input logic [15:0] l1,
    input logic [15:0] epc, input logic [2:0] ecnt,
    input logic eovf, input logic eunf);
    vec_t v;
    v.stall = st; v.flush = fl; v.fa = fa; v.ret = rt;
    v.jv = jv; v.jc = jc;
    v.a0 = a0; v.a1 = a1; v.l0 = l0; v.l1 = l1;
    v.epc = epc; v.ecnt = ecnt; v.eovf = eovf; v.eunf = eunf;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] epc,
                       input logic [2:0] ecnt, input logic eovf,
                       input logic eunf);
    checks++;
    if (pc !== epc || ras_count !== ecnt ||
        ras_overflow !== eovf || ras_underflow !== eunf) begin
      errors++;
      $display("FAIL %s: got pc=%h cnt=%0d ovf=%b unf=%b, want pc=%h cnt=%0d ovf=%b unf=%b",
               name, pc, ras_count, ras_overflow, ras_underflow,
               epc, ecnt, eovf, eunf);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; flush_address = '0; ret_valid = 0;
    jmp_valid = '0; jmp_call = '0; jmp_address = '0; jmp_link = '0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;

    //  st fl fa       rt jv     jc     a0       a1       l0       l1       epc      cnt ovf unf
    add(0, 0, 16'h0,   0, 2'b00, 2'b00, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0001, 0, 0, 0);
    add(0, 0, 16'h0,   0, 2'b00, 2'b00, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0002, 0, 0, 0);
    add(0, 0, 16'h0,   0, 2'b11, 2'b10, 16'h0100,16'h0200,16'h0,   16'h0AAA,16'h0100, 0, 0, 0);
    add(1, 1, 16'h0999,0, 2'b00, 2'b00, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0100, 0, 0, 0);
    add(0, 0, 16'h0,   0, 2'b01, 2'b01, 16'h0300,16'h0,   16'h0011,16'h0,   16'h0300, 1, 0, 0);
    add(0, 0, 16'h0,   1, 2'b00, 2'b00, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0011, 0, 0, 0);
    add(0, 0, 16'h0,   1, 2'b00, 2'b00, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0012, 0, 0, 1);
    for (int i = 1; i <= 5; i++)
      add(0, 0, 16'h0, 0, 2'b01, 2'b01, 16'h0500 + 16'(i), 16'h0,
          16'(i), 16'h0, 16'h0500 + 16'(i),
          (i > 4) ? 3'd4 : 3'(i), (i == 5), 1);
    add(0, 1, 16'h0400,1, 2'b01, 2'b01, 16'h0888,16'h0,   16'h0077,16'h0,   16'h0400, 4, 1, 1);
    add(0, 0, 16'h0,   1, 2'b00, 2'b00, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0005, 3, 1, 1);
    add(0, 0, 16'h0,   1, 2'b00, 2'b00, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0004, 2, 1, 1);
    add(0, 0, 16'h0,   1, 2'b00, 2'b00, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0003, 1, 1, 1);
    add(0, 0, 16'h0,   1, 2'b00, 2'b00, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0002, 0, 1, 1);
    add(0, 0, 16'h0,   1, 2'b10, 2'b10, 16'h0,   16'h0777,16'h0,   16'h0066,16'h0003, 0, 1, 1);
    add(0, 1, 16'hFFFE,0, 2'b00, 2'b00, 16'h0,   16'h0,   16'h0,   16'h0,   16'hFFFE, 0, 1, 1);
    add(0, 0, 16'h0,   0, 2'b00, 2'b00, 16'h0,   16'h0,   16'h0,   16'h0,   16'hFFFF, 0, 1, 1);
    add(0, 0, 16'h0,   0, 2'b00, 2'b00, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0000, 0, 1, 1);
    add(1, 0, 16'h0,   0, 2'b00, 2'b00, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0000, 0, 1, 1);
    add(0, 0, 16'h0,   0, 2'b10, 2'b10, 16'h0,   16'h0234,16'h0,   16'h0042,16'h0234, 1, 1, 1);
    add(1, 0, 16'h0,   1, 2'b00, 2'b00, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0234, 1, 1, 1);
    add(0, 0, 16'h0,   0, 2'b01, 2'b00, 16'h0042,16'h0,   16'h0,   16'h0,   16'h0042, 1, 1, 1);

    repeat (2) @(posedge clk);
    #1 check("reset_state", 16'h0000, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      stall         = vq[i].stall;
      flush         = vq[i].flush;
      flush_address = vq[i].fa;
      ret_valid     = vq[i].ret;
      jmp_valid     = vq[i].jv;
      jmp_call      = vq[i].jc;
      jmp_address   = {vq[i].a1, vq[i].a0};
      jmp_link      = {vq[i].l1, vq[i].l0};
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vq[i].epc, vq[i].ecnt,
               vq[i].eovf, vq[i].eunf);
      @(negedge clk);
    end

    idle_inputs();
    #2 reset = 1'b0;
    #1 check("async_reset", 16'h0000, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1 check($sformatf("post_reset_inc%0d", i), 16'(i), 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
